seq_mod_select: RTL and testbench

SEQ_MOD_SELECT -- requirements
Module: seq_mod_select

---
 rtl/seq_mod_select_pkg.sv | 18 +
 rtl/seq_mod_select_if.sv | 29 ++
 rtl/seq_mod_select_mod_step.sv | 21 ++
 rtl/seq_mod_select.sv | 93 +++++++++
 tb/tb_seq_mod_select.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/seq_mod_select_pkg.sv
// Shared types and constants for the sequential modulo-select block.
// Holds the FSM state encoding and the default operand width.
package seq_mod_select_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DATAWIDTH_DEFAULT = 64;
  localparam int CNT_W_DEFAULT     = $clog2(DATAWIDTH_DEFAULT + 1);

  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/seq_mod_select_if.sv
// Operand/result handshake bundle for seq_mod_select.
// Both sides use valid/ready: a transfer happens on a rising edge where valid && ready are both high.
interface seq_mod_select_if
  import seq_mod_select_pkg::*;
#(
  parameter int DATAWIDTH = DATAWIDTH_DEFAULT
);

  logic                 in_valid;
  logic                 in_ready;
  logic [DATAWIDTH-1:0] a;
  logic [DATAWIDTH-1:0] c;
  logic [DATAWIDTH-1:0] zero;
  logic [DATAWIDTH-1:0] z;
  logic                 out_valid;
  logic                 out_ready;
  logic                 busy;

  modport master (
    output in_valid, a, c, zero, out_ready,
    input  in_ready, z, out_valid, busy
  );

  modport slave (
    input  in_valid, a, c, zero, out_ready,
    output in_ready, z, out_valid, busy
  );

endinterface

// File: rtl/seq_mod_select_mod_step.sv
// One restoring-remainder step: shift in the next dividend bit, subtract the divisor if it fits.
// The borrow out of the wide trial subtraction decides whether the subtraction is kept.
module mod_step #(
  parameter int DATAWIDTH = 64
) (
  input  logic [DATAWIDTH:0]   rem,
  input  logic                 din,
  input  logic [DATAWIDTH-1:0] div,
  output logic [DATAWIDTH:0]   rem_next
);

  logic [DATAWIDTH+1:0] shifted;
  logic [DATAWIDTH+1:0] trial;

  always_comb begin
    shifted  = {rem, din};
    trial    = shifted - {2'b00, div};
    rem_next = trial[DATAWIDTH+1] ? {rem[DATAWIDTH-1:0], din} : trial[DATAWIDTH:0];
  end

endmodule

// File: rtl/seq_mod_select.sv
// Computes g = a mod c with a bit-serial restoring remainder, then z = (g == zero) ? a-1 : c+1.
// A zero divisor skips the serial loop and treats g as a.
module seq_mod_select
  import seq_mod_select_pkg::*;
#(
  parameter int DATAWIDTH = DATAWIDTH_DEFAULT
) (
  input  logic               Clk,
  input  logic               Rst,
  seq_mod_select_if.slave    bus,
  output state_t             state_dbg
);

  localparam int CW = cnt_width(DATAWIDTH);

  state_t               state, state_nx;
  logic [DATAWIDTH-1:0] a_q, c_q, zero_q, a_sh, z_q;
  logic [DATAWIDTH:0]   rem, rem_nx;
  logic [CW-1:0]        cnt;
  logic                 accept, last_step;
  logic [DATAWIDTH-1:0] g, op_a, op_c, op_zero, z_sel;

  assign accept    = bus.in_valid && (state == IDLE);
  assign last_step = (state == CALC) && (cnt == CW'(DATAWIDTH - 1));

  mod_step #(.DATAWIDTH(DATAWIDTH)) u_step (
    .rem      (rem),
    .din      (a_sh[DATAWIDTH-1]),
    .div      (c_q),
    .rem_next (rem_nx)
  );

  // In IDLE the select works straight off the inputs, which serves the zero-divisor path.
  always_comb begin
    op_a    = a_q;
    op_c    = c_q;
    op_zero = zero_q;
    g       = rem_nx[DATAWIDTH-1:0];
    if (state == IDLE) begin
      op_a    = bus.a;
      op_c    = bus.c;
      op_zero = bus.zero;
      g       = bus.a;
    end
    z_sel = (g == op_zero) ? (op_a - DATAWIDTH'(1)) : (op_c + DATAWIDTH'(1));
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (accept) state_nx = (bus.c == '0) ? DONE : CALC;
      CALC:    if (last_step) state_nx = DONE;
      DONE:    if (bus.out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state  <= IDLE;
      z_q    <= '0;
      rem    <= '0;
      cnt    <= '0;
      a_q    <= '0;
      c_q    <= '0;
      zero_q <= '0;
      a_sh   <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        a_q    <= bus.a;
        c_q    <= bus.c;
        zero_q <= bus.zero;
        a_sh   <= bus.a;
        rem    <= '0;
        cnt    <= '0;
        if (bus.c == '0) z_q <= z_sel;
      end else if (state == CALC) begin
        rem  <= rem_nx;
        a_sh <= {a_sh[DATAWIDTH-2:0], 1'b0};
        cnt  <= cnt + CW'(1);
        if (last_step) z_q <= z_sel;
      end
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state != IDLE);
  assign bus.z         = z_q;
  assign state_dbg     = state;

endmodule

// File: tb/tb_seq_mod_select.sv
// Self-checking bench for seq_mod_select: directed corner cases, random operands, backpressure and reset abort.
module tb_seq_mod_select;
  import seq_mod_select_pkg::*;

  localparam int W = 64;
  localparam logic [W-1:0] ONES = {W{1'b1}};

  logic   Clk;
  logic   Rst;
  state_t state_dbg;
  int     n_checks;
  int     n_fail;
  logic [W-1:0] exp_q[$];

  seq_mod_select_if #(.DATAWIDTH(W)) bus ();

  seq_mod_select #(.DATAWIDTH(W)) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [W-1:0] ref_g(input logic [W-1:0] a, input logic [W-1:0] c);
    return (c == 0) ? a : (a % c);
  endfunction

  function automatic logic [W-1:0] ref_z(input logic [W-1:0] a, input logic [W-1:0] c,
                                         input logic [W-1:0] zr);
    return (ref_g(a, c) == zr) ? a - 1 : c + 1;
  endfunction

  function automatic logic [W-1:0] rand64();
    return {$urandom, $urandom};
  endfunction

  // driver: one full operation, checks latency and result, then consumes it
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] c, input logic [W-1:0] zr,
                        input string name);
    logic [W-1:0] exp_z;
    int lat, exp_lat, waited;
    exp_q.push_back(ref_z(a, c, zr));
    exp_lat = (c == 0) ? 1 : W + 1;
    @(negedge Clk);
    bus.in_valid = 1'b1; bus.a = a; bus.c = c; bus.zero = zr; bus.out_ready = 1'b0;
    waited = 0;
    while (!bus.in_ready && waited < 200) begin
      @(negedge Clk);
      waited++;
    end
    n_checks++;
    if (!bus.in_ready) begin
      n_fail++;
      $display("FAIL %s accept_timeout in_ready=%0b required 1", name, bus.in_ready);
    end
    @(posedge Clk);
    #1;
    bus.in_valid = 1'b0; bus.a = rand64(); bus.c = rand64(); bus.zero = rand64();
    lat = 0;
    while (lat < 200) begin
      @(negedge Clk);
      lat++;
      if (bus.out_valid) break;
    end
    exp_z = exp_q.pop_front();
    n_checks++;
    if (lat !== exp_lat) begin
      n_fail++;
      $display("FAIL %s latency got %0d required %0d", name, lat, exp_lat);
    end
    n_checks++;
    if (bus.z !== exp_z) begin
      n_fail++;
      $display("FAIL %s z got %h required %h", name, bus.z, exp_z);
    end
    bus.out_ready = 1'b1;
    @(posedge Clk);
    #1;
    bus.out_ready = 1'b0;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.z !== exp_z) begin
      n_fail++;
      $display("FAIL %s consume out_valid=%0b z=%h required 0 and %h", name, bus.out_valid, bus.z, exp_z);
    end
  endtask

  task automatic test_reset();
    @(negedge Clk);
    Rst = 1'b1;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    Rst = 1'b0;
    n_checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.z !== '0) begin
      n_fail++;
      $display("FAIL reset in_ready=%0b out_valid=%0b busy=%0b z=%h required 1 0 0 0",
               bus.in_ready, bus.out_valid, bus.busy, bus.z);
    end
  endtask

  task automatic test_directed();
    run_op(64'd10, 64'd3, 64'd1, "mod_hit");
    run_op(64'd10, 64'd3, 64'd0, "mod_miss");
    run_op(64'd12, 64'd4, 64'd0, "mod_exact");
    run_op(64'd5, 64'd0, 64'd5, "div0_hit");
    run_op(64'd0, 64'd0, 64'd1, "div0_miss");
    run_op(64'd0, 64'd1, 64'd0, "wrap_a_minus_1");
    run_op(64'd5, ONES, 64'd0, "wrap_c_plus_1");
    run_op(ONES, ONES, 64'd0, "a_eq_c_max");
  endtask

  task automatic test_random();
    logic [W-1:0] a, c, zr;
    for (int i = 0; i < 24; i++) begin
      a = rand64();
      case ($urandom_range(0, 3))
        0:       c = '0;
        1:       c = W'($urandom_range(1, 20));
        2:       c = rand64();
        default: c = ONES;
      endcase
      zr = ($urandom_range(0, 1) == 1) ? ref_g(a, c) : rand64();
      run_op(a, c, zr, $sformatf("random_%0d", i));
    end
  endtask

  task automatic test_backpressure();
    int waited;
    logic ok;
    @(negedge Clk);
    bus.in_valid = 1'b1; bus.a = 64'd100; bus.c = 64'd7; bus.zero = 64'd2; bus.out_ready = 1'b0;
    @(posedge Clk);
    #1;
    bus.in_valid = 1'b0;
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      bus.in_valid = i[0]; bus.a = rand64(); bus.c = 64'd0; bus.zero = rand64();
      if (bus.in_ready !== 1'b0 || bus.busy !== 1'b1) ok = 1'b0;
    end
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL calc_busy in_ready=%0b busy=%0b required 0 1", bus.in_ready, bus.busy);
    end
    waited = 0;
    while (!bus.out_valid && waited < 200) begin
      @(negedge Clk);
      bus.in_valid = ~bus.in_valid;
      waited++;
    end
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge Clk);
      bus.in_valid = 1'b1; bus.a = rand64(); bus.c = rand64();
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.z !== 64'd99 || bus.in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_%0d out_valid=%0b z=%h in_ready=%0b required 1 63 0",
                 i, bus.out_valid, bus.z, bus.in_ready);
      end
    end
    // keep in_valid high across the consume edge with the next operand set
    @(negedge Clk);
    bus.in_valid = 1'b1; bus.a = 64'd12; bus.c = 64'd4; bus.zero = 64'd0; bus.out_ready = 1'b1;
    @(posedge Clk);
    #1;
    bus.out_ready = 1'b0;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0 || bus.z !== 64'd99) begin
      n_fail++;
      $display("FAIL consume_edge out_valid=%0b in_ready=%0b busy=%0b z=%h required 0 1 0 63",
               bus.out_valid, bus.in_ready, bus.busy, bus.z);
    end
    @(posedge Clk);
    #1;
    bus.in_valid = 1'b0;
    n_checks++;
    if (bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL back_to_back_accept busy=%0b required 1", bus.busy);
    end
    waited = 0;
    while (!bus.out_valid && waited < 200) begin
      @(negedge Clk);
      waited++;
    end
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.z !== 64'd11) begin
      n_fail++;
      $display("FAIL back_to_back_z out_valid=%0b z=%h required 1 b", bus.out_valid, bus.z);
    end
    @(negedge Clk);
    bus.out_ready = 1'b1;
    @(posedge Clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset_abort();
    logic seen;
    @(negedge Clk);
    bus.in_valid = 1'b1; bus.a = 64'd1234567; bus.c = 64'd97; bus.zero = 64'd0; bus.out_ready = 1'b1;
    @(posedge Clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (20) @(posedge Clk);
    @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);
    Rst = 1'b0;
    n_checks++;
    if (bus.busy !== 1'b0 || bus.in_ready !== 1'b1 || bus.z !== '0 || bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_calc busy=%0b in_ready=%0b z=%h out_valid=%0b required 0 1 0 0",
               bus.busy, bus.in_ready, bus.z, bus.out_valid);
    end
    seen = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(negedge Clk);
      if (bus.out_valid) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_no_pulse out_valid_seen=%0b required 0", seen);
    end
    // abort from DONE, with reset and consume on the same edge
    @(negedge Clk);
    bus.in_valid = 1'b1; bus.a = 64'd9; bus.c = 64'd0; bus.zero = 64'd1; bus.out_ready = 1'b0;
    @(negedge Clk);
    bus.in_valid = 1'b0; bus.out_ready = 1'b1; Rst = 1'b1;
    @(negedge Clk);
    Rst = 1'b0; bus.out_ready = 1'b0;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.z !== '0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_in_done out_valid=%0b z=%h busy=%0b required 0 0 0",
               bus.out_valid, bus.z, bus.busy);
    end
    run_op(64'd7, 64'd2, 64'd1, "after_reset");
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    Rst = 1'b1;
    bus.in_valid = 1'b0; bus.a = '0; bus.c = '0; bus.zero = '0; bus.out_ready = 1'b0;
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
